vend_datapath: RTL and testbench

Coin-handling datapath for the soda vending controller. It converts coin-acceptor strobes into coin values and holds one pending coin in the Y register. It accumulates credit in TOTAL, compares TOTAL against PRICE and computes CHANGE. The controller FSM drives every load/reset strobe. This block returns `start` (a coin is pending) and `comp_result` (credit ≥ price) to the FSM.

---
 rtl/vend_datapath.sv | 132 +++++++++++++
 tb/tb_vend_datapath.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_datapath.sv
// Coin-handling datapath for the soda vending controller: coin edge detect,
// pending-coin Y register, saturating TOTAL credit, price compare and CHANGE.
module vend_datapath #(
    parameter int unsigned PRICE   = 20,
    parameter int unsigned TOTAL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coin_valid,
    input  logic [1:0]         coin_sel,
    input  logic               y_ld,
    input  logic               y_rst,
    input  logic               total_ld,
    input  logic               total_rst,
    input  logic               change_ld,
    input  logic               change_rst,
    output logic               start,
    output logic               comp_result,
    output logic [TOTAL_W-1:0] total,
    output logic [TOTAL_W-1:0] change,
    output logic               change_valid,
    output logic               coin_reject,
    output logic               overflow
);

    localparam logic [TOTAL_W-1:0] PRICE_V = TOTAL_W'(PRICE);

    logic               r_coin_valid_q;
    logic [TOTAL_W-1:0] r_y;
    logic               r_pending;
    logic [TOTAL_W-1:0] r_total;
    logic               r_overflow;
    logic [TOTAL_W-1:0] r_change;
    logic               r_change_valid;
    logic               r_coin_reject;

    logic [TOTAL_W-1:0] w_coin_val;
    logic               w_ev;
    logic               w_consume;
    logic               w_accept;
    logic               w_reject;
    logic [TOTAL_W:0]   w_sum;
    logic               w_sat;
    logic               w_comp;
    logic [TOTAL_W-1:0] w_change_nxt;

    // Coin type to value in cents
    always_comb begin
        w_coin_val = '0;
        case (coin_sel)
            2'b01:   w_coin_val = TOTAL_W'(5);
            2'b10:   w_coin_val = TOTAL_W'(10);
            2'b11:   w_coin_val = TOTAL_W'(25);
            default: w_coin_val = '0;
        endcase
    end

    // A held strobe counts once; a coin may land in Y the same cycle the old one is consumed
    assign w_ev      = coin_valid & ~r_coin_valid_q & (coin_sel != 2'b00);
    assign w_consume = total_ld & r_pending;
    assign w_accept  = w_ev & y_ld & ~y_rst & (~r_pending | w_consume);
    assign w_reject  = w_ev & ~w_accept;

    assign w_sum        = {1'b0, r_total} + {1'b0, r_y};
    assign w_sat        = w_sum[TOTAL_W];
    assign w_comp       = (r_total >= PRICE_V);
    assign w_change_nxt = w_comp ? (r_total - PRICE_V) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coin_valid_q <= 1'b0;
            r_coin_reject  <= 1'b0;
        end else begin
            r_coin_valid_q <= coin_valid;
            r_coin_reject  <= w_reject;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_pending <= 1'b0;
        end else if (y_rst) begin
            r_y       <= '0;
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_y       <= w_coin_val;
            r_pending <= 1'b1;
        end else if (w_consume) begin
            r_y       <= '0;
            r_pending <= 1'b0;
        end
    end

    // Credit saturates at all-ones; overflow stays set until the next clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total    <= '0;
            r_overflow <= 1'b0;
        end else if (total_rst) begin
            r_total    <= '0;
            r_overflow <= 1'b0;
        end else if (w_consume) begin
            r_total    <= w_sat ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];
            r_overflow <= r_overflow | w_sat;
        end
    end

    // CHANGE samples the pre-clear TOTAL when vend clears credit on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_change       <= '0;
            r_change_valid <= 1'b0;
        end else begin
            r_change_valid <= change_ld & ~change_rst;
            if (change_rst) begin
                r_change <= '0;
            end else if (change_ld) begin
                r_change <= w_change_nxt;
            end
        end
    end

    assign start        = r_pending;
    assign comp_result  = w_comp;
    assign total        = r_total;
    assign change       = r_change;
    assign change_valid = r_change_valid;
    assign coin_reject  = r_coin_reject;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_vend_datapath.sv
// Bench for vend_datapath: two instances (8-bit/price 20 and 5-bit/price 30)
// driven in parallel and checked against a cycle-level model of the coin rules.
module tb_vend_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cv;
    logic [1:0] sel;
    logic       y_ld, y_rst, t_ld, t_rst, c_ld, c_rst;

    logic       a_start, a_comp, a_cv, a_rej, a_ovf;
    logic [7:0] a_tot, a_chg;
    logic       b_start, b_comp, b_cv, b_rej, b_ovf;
    logic [4:0] b_tot, b_chg;

    logic [20:0] obs_a, obs_b;

    int n_vec = 0;
    int n_err = 0;

    int COIN[4]    = '{0, 5, 10, 25};
    int LIM[2]     = '{255, 31};
    int PRICE_M[2] = '{20, 30};

    int m_y[2], m_tot[2], m_chg[2];
    bit m_pend[2], m_rej[2], m_cvld[2], m_ovf[2];
    bit m_cvq;

    always #5 clk = ~clk;

    vend_datapath #(.PRICE(20), .TOTAL_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .coin_valid(cv), .coin_sel(sel),
        .y_ld(y_ld), .y_rst(y_rst), .total_ld(t_ld), .total_rst(t_rst),
        .change_ld(c_ld), .change_rst(c_rst),
        .start(a_start), .comp_result(a_comp), .total(a_tot), .change(a_chg),
        .change_valid(a_cv), .coin_reject(a_rej), .overflow(a_ovf)
    );

    vend_datapath #(.PRICE(30), .TOTAL_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .coin_valid(cv), .coin_sel(sel),
        .y_ld(y_ld), .y_rst(y_rst), .total_ld(t_ld), .total_rst(t_rst),
        .change_ld(c_ld), .change_rst(c_rst),
        .start(b_start), .comp_result(b_comp), .total(b_tot), .change(b_chg),
        .change_valid(b_cv), .coin_reject(b_rej), .overflow(b_ovf)
    );

    assign obs_a = {a_start, a_comp, a_cv, a_rej, a_ovf, a_chg, a_tot};
    assign obs_b = {b_start, b_comp, b_cv, b_rej, b_ovf, 3'b000, b_chg, 3'b000, b_tot};

    function automatic logic [20:0] exp_pack(input int i);
        int ch, tt;
        ch = m_chg[i];
        tt = m_tot[i];
        return {m_pend[i], (m_tot[i] >= PRICE_M[i]), m_cvld[i], m_rej[i], m_ovf[i],
                ch[7:0], tt[7:0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_y[i] = 0; m_tot[i] = 0; m_chg[i] = 0;
            m_pend[i] = 1'b0; m_rej[i] = 1'b0; m_cvld[i] = 1'b0; m_ovf[i] = 1'b0;
        end
        m_cvq = 1'b0;
    endtask

    // One clock of the coin/credit/change rules, applied to both instances
    task automatic model_step();
        bit ev, cons, acc;
        int s;
        ev = cv && !m_cvq && (sel != 2'b00);
        for (int i = 0; i < 2; i++) begin
            cons = t_ld && m_pend[i];
            acc  = ev && y_ld && !y_rst && (!m_pend[i] || cons);
            m_rej[i]  = ev && !acc;
            m_cvld[i] = c_ld && !c_rst;
            if (c_rst) m_chg[i] = 0;
            else if (c_ld) m_chg[i] = (m_tot[i] >= PRICE_M[i]) ? m_tot[i] - PRICE_M[i] : 0;
            if (t_rst) begin
                m_tot[i] = 0; m_ovf[i] = 1'b0;
            end else if (cons) begin
                s = m_tot[i] + m_y[i];
                if (s > LIM[i]) begin m_tot[i] = LIM[i]; m_ovf[i] = 1'b1; end
                else m_tot[i] = s;
            end
            if (y_rst) begin m_y[i] = 0; m_pend[i] = 1'b0; end
            else if (acc) begin m_y[i] = COIN[sel]; m_pend[i] = 1'b1; end
            else if (cons) begin m_y[i] = 0; m_pend[i] = 1'b0; end
        end
        m_cvq = cv;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Controller-like coin sequence: strobe, then one accumulate cycle, then idle
    task automatic coin(input logic [1:0] s);
        cv = 1'b1; sel = s; tick();
        cv = 1'b0; sel = 2'b00; t_ld = 1'b1; tick();
        t_ld = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cv = 1'b0; sel = 2'b00;
        y_ld = 1'b0; y_rst = 1'b0; t_ld = 1'b0; t_rst = 1'b0; c_ld = 1'b0; c_rst = 1'b0;
        model_clear();
        #12;
        n_vec++; if (obs_a !== 21'd0) begin n_err++; $display("FAIL reset_a: got %h want 0", obs_a); end
        n_vec++; if (obs_b !== 21'd0) begin n_err++; $display("FAIL reset_b: got %h want 0", obs_b); end
        rst_n = 1'b1;
        tick();
        y_ld = 1'b1;
        coin(2'b01);
        coin(2'b10);
        cv = 1'b1; sel = 2'b01; tick();
        n_vec++; if (a_tot !== 8'd15 || a_start !== 1'b1) begin n_err++; $display("FAIL accum15: got tot=%0d start=%b want 15/1", a_tot, a_start); end
        #3 rst_n = 1'b0;
        #1;
        model_clear();
        n_vec++; if (obs_a !== 21'd0 || obs_b !== 21'd0) begin n_err++; $display("FAIL async_reset: got %h/%h want 0/0", obs_a, obs_b); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_vec++; if (a_start !== 1'b1 || a_rej !== 1'b0) begin n_err++; $display("FAIL held_first: got start=%b rej=%b want 1/0", a_start, a_rej); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (a_rej !== 1'b0 || a_start !== 1'b1) begin n_err++; $display("FAIL held_once: got start=%b rej=%b want 1/0", a_start, a_rej); end
        end
        cv = 1'b0; t_ld = 1'b1; tick();
        t_ld = 1'b0; tick();
        n_vec++; if (a_tot !== 8'd5) begin n_err++; $display("FAIL held_total: got %0d want 5", a_tot); end
        t_rst = 1'b1; tick(); t_rst = 1'b0;
    endtask

    task automatic test_two_dimes();
        coin(2'b10);
        n_vec++; if (a_tot !== 8'd10 || a_comp !== 1'b0) begin n_err++; $display("FAIL dime1: got tot=%0d comp=%b want 10/0", a_tot, a_comp); end
        tick();
        cv = 1'b1; sel = 2'b10; tick();
        n_vec++; if (a_comp !== 1'b0 || a_start !== 1'b1) begin n_err++; $display("FAIL dime2_edge: got comp=%b start=%b want 0/1", a_comp, a_start); end
        cv = 1'b0; sel = 2'b00; t_ld = 1'b1; tick();
        n_vec++; if (a_tot !== 8'd20 || a_comp !== 1'b1) begin n_err++; $display("FAIL dime2_total: got tot=%0d comp=%b want 20/1", a_tot, a_comp); end
        t_ld = 1'b0; tick();
        c_ld = 1'b1; t_rst = 1'b1; tick();
        c_ld = 1'b0; t_rst = 1'b0;
        n_vec++; if (a_chg !== 8'd0 || a_cv !== 1'b1 || a_tot !== 8'd0) begin n_err++; $display("FAIL vend20: got chg=%0d cv=%b tot=%0d want 0/1/0", a_chg, a_cv, a_tot); end
        tick();
        n_vec++; if (a_cv !== 1'b0) begin n_err++; $display("FAIL cv_pulse: got %b want 0", a_cv); end
        c_rst = 1'b1; tick(); c_rst = 1'b0;
        n_vec++; if (obs_a !== exp_pack(0) || obs_b !== exp_pack(1)) begin n_err++; $display("FAIL dimes_model: got %h/%h want %h/%h", obs_a, obs_b, exp_pack(0), exp_pack(1)); end
    endtask

    task automatic test_quarter();
        coin(2'b11);
        n_vec++; if (a_tot !== 8'd25 || a_comp !== 1'b1 || b_comp !== 1'b0) begin n_err++; $display("FAIL quarter: got tot=%0d comp=%b/%b want 25/1/0", a_tot, a_comp, b_comp); end
        c_ld = 1'b1; t_rst = 1'b1; tick();
        c_ld = 1'b0; t_rst = 1'b0;
        n_vec++; if (a_chg !== 8'd5 || a_tot !== 8'd0 || b_chg !== 5'd0) begin n_err++; $display("FAIL vend25: got chg=%0d tot=%0d bchg=%0d want 5/0/0", a_chg, a_tot, b_chg); end
        c_rst = 1'b1; tick(); c_rst = 1'b0;
    endtask

    task automatic test_reject();
        cv = 1'b1; sel = 2'b01; tick();
        cv = 1'b0; sel = 2'b00; tick();
        cv = 1'b1; sel = 2'b10; tick();
        n_vec++; if (a_rej !== 1'b1 || a_start !== 1'b1) begin n_err++; $display("FAIL reject: got rej=%b start=%b want 1/1", a_rej, a_start); end
        cv = 1'b0; sel = 2'b00; tick();
        n_vec++; if (a_rej !== 1'b0) begin n_err++; $display("FAIL reject_pulse: got %b want 0", a_rej); end
        cv = 1'b1; sel = 2'b10; t_ld = 1'b1; tick();
        n_vec++; if (a_rej !== 1'b0 || a_start !== 1'b1 || a_tot !== 8'd5) begin n_err++; $display("FAIL swap: got rej=%b start=%b tot=%0d want 0/1/5", a_rej, a_start, a_tot); end
        cv = 1'b0; sel = 2'b00; tick();
        n_vec++; if (a_tot !== 8'd15 || a_start !== 1'b0) begin n_err++; $display("FAIL swap_dime: got tot=%0d start=%b want 15/0", a_tot, a_start); end
        t_ld = 1'b0; t_rst = 1'b1; tick(); t_rst = 1'b0;
    endtask

    task automatic test_overflow();
        coin(2'b11);
        coin(2'b11);
        n_vec++; if (b_tot !== 5'd31 || b_ovf !== 1'b1 || a_tot !== 8'd50 || a_ovf !== 1'b0) begin n_err++; $display("FAIL saturate: got btot=%0d bovf=%b atot=%0d aovf=%b want 31/1/50/0", b_tot, b_ovf, a_tot, a_ovf); end
        c_ld = 1'b1; tick(); c_ld = 1'b0;
        n_vec++; if (b_chg !== 5'd1 || a_chg !== 8'd30) begin n_err++; $display("FAIL ovf_change: got bchg=%0d achg=%0d want 1/30", b_chg, a_chg); end
        t_rst = 1'b1; tick(); t_rst = 1'b0;
        n_vec++; if (b_ovf !== 1'b0 || b_tot !== 5'd0 || b_chg !== 5'd1) begin n_err++; $display("FAIL ovf_clear: got ovf=%b tot=%0d chg=%0d want 0/0/1", b_ovf, b_tot, b_chg); end
        c_rst = 1'b1; tick(); c_rst = 1'b0;
    endtask

    task automatic test_null_and_yrst();
        cv = 1'b1; sel = 2'b00; tick();
        n_vec++; if (a_start !== 1'b0 || a_rej !== 1'b0) begin n_err++; $display("FAIL null_coin: got start=%b rej=%b want 0/0", a_start, a_rej); end
        cv = 1'b0; tick();
        cv = 1'b1; sel = 2'b11; y_rst = 1'b1; tick();
        n_vec++; if (a_start !== 1'b0 || a_rej !== 1'b1 || b_rej !== 1'b1) begin n_err++; $display("FAIL yrst_drop: got start=%b rej=%b/%b want 0/1/1", a_start, a_rej, b_rej); end
        cv = 1'b0; sel = 2'b00; y_rst = 1'b0; t_ld = 1'b1; tick();
        t_ld = 1'b0;
        n_vec++; if (a_rej !== 1'b0 || a_tot !== 8'd0) begin n_err++; $display("FAIL yrst_after: got rej=%b tot=%0d want 0/0", a_rej, a_tot); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cv    = 1'($urandom_range(0, 1));
            sel   = 2'($urandom_range(0, 3));
            y_ld  = ($urandom_range(0, 7) != 0);
            y_rst = ($urandom_range(0, 9) == 0);
            t_ld  = ($urandom_range(0, 2) == 0);
            t_rst = ($urandom_range(0, 11) == 0);
            c_ld  = ($urandom_range(0, 5) == 0);
            c_rst = ($urandom_range(0, 7) == 0);
            tick();
            n_vec++; if (obs_a !== exp_pack(0)) begin n_err++; $display("FAIL rand_a cycle %0d: got %h want %h", k, obs_a, exp_pack(0)); end
            n_vec++; if (obs_b !== exp_pack(1)) begin n_err++; $display("FAIL rand_b cycle %0d: got %h want %h", k, obs_b, exp_pack(1)); end
        end
    endtask

    initial begin
        test_reset();
        test_two_dimes();
        test_quarter();
        test_reject();
        test_overflow();
        test_null_and_yrst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
